// File: rtl/adc_offset_remover_pkg.sv
// rtl/adc_offset_remover_pkg.sv - shared sample constants, calibration states and symmetric saturation
package adc_offset_remover_pkg;

  localparam int ADC_W        = 8;
  localparam int ADC_MID_CODE = 127;
  localparam int SAMPLE_MAX   = 127;
  localparam int SAMPLE_MIN   = -127;

  typedef enum logic {
    CAL   = 1'b0,
    TRACK = 1'b1
  } cal_state_e;

  // Clamp to [-127, +127] so the output range stays symmetric and -128 never appears.
  function automatic logic [ADC_W-1:0] sat_sym(input logic signed [ADC_W:0] d);
    logic [ADC_W-1:0] r;
    int               di;
    di = d;
    if (di > SAMPLE_MAX) begin
      r = ADC_W'(SAMPLE_MAX);
    end else if (di < SAMPLE_MIN) begin
      r = ADC_W'(SAMPLE_MIN);
    end else begin
      r = d[ADC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_offset_remover_if.sv
// rtl/adc_offset_remover_if.sv - valid/ready sample stream
interface adc_offset_remover_if #(
  parameter int DATA_W = 8
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/adc_offset_remover_dc_block_avg.sv
// rtl/adc_offset_remover_dc_block_avg.sv - block-average DC estimator over 2^AVG_LOG2 samples
module adc_offset_remover_dc_block_avg
  import adc_offset_remover_pkg::*;
#(
  parameter int DATA_W   = ADC_W,
  parameter int AVG_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic [DATA_W-1:0] est,
  output logic              est_valid
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (AVG_LOG2 - 1);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W:0]      sum_rnd;
  logic [DATA_W:0]     quot;

  always_comb begin
    sum       = acc_q + ACC_W'(in_data);
    sum_rnd   = {1'b0, sum} + RND;
    quot      = sum_rnd[ACC_W:AVG_LOG2];
    est       = quot[DATA_W] ? '1 : quot[DATA_W-1:0];
    est_valid = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      // The window-closing sample is folded into the estimate, then the next window starts empty.
      if (cnt_q == '1) begin
        acc_d     = '0;
        cnt_d     = '0;
        est_valid = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_offset_remover.sv
// rtl/adc_offset_remover.sv - removes ADC DC level and emits saturated signed samples
module adc_offset_remover
  import adc_offset_remover_pkg::*;
#(
  parameter int DATA_W   = ADC_W,
  parameter int AVG_LOG2 = 10,
  parameter int MID_CODE = ADC_MID_CODE
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_offset_remover_if.slave  s,
  adc_offset_remover_if.master m,
  output logic [DATA_W-1:0]   dc_est,
  output logic                dc_locked,
  input  logic                cal_restart
);

  logic                     en;
  logic                     accept;
  logic signed [DATA_W:0]   diff;
  logic                     s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]        s1_data_q, s1_data_d;
  logic                     m_valid_q, m_valid_d;
  logic [DATA_W-1:0]        m_data_q, m_data_d;
  logic [DATA_W-1:0]        dc_est_q, dc_est_d;
  cal_state_e               state_q, state_d;
  logic [DATA_W-1:0]        est;
  logic                     est_valid;

  // Both stages advance together, so a stalled output freezes the whole pipe.
  always_comb begin
    en         = !m_valid_q || m.ready;
    accept     = s.valid && en;
    diff       = $signed({1'b0, s1_data_q}) - $signed({1'b0, dc_est_q});
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    if (en) begin
      s1_valid_d = s.valid;
      s1_data_d  = s.data;
      m_valid_d  = s1_valid_q;
      m_data_d   = sat_sym(diff);
    end
  end

  always_comb begin
    state_d  = state_q;
    dc_est_d = dc_est_q;
    if (cal_restart) begin
      state_d  = CAL;
      dc_est_d = DATA_W'(MID_CODE);
    end else if (est_valid) begin
      state_d  = TRACK;
      dc_est_d = est;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      dc_est_q   <= DATA_W'(MID_CODE);
      state_q    <= CAL;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      dc_est_q   <= dc_est_d;
      state_q    <= state_d;
    end
  end

  adc_offset_remover_dc_block_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_data   (s.data),
    .clear     (cal_restart),
    .est       (est),
    .est_valid (est_valid)
  );

  assign s.ready   = en;
  assign m.valid   = m_valid_q;
  assign m.data    = m_data_q;
  assign dc_est    = dc_est_q;
  assign dc_locked = (state_q == TRACK);

endmodule

// File: tb/tb_adc_offset_remover.sv
// tb/tb_adc_offset_remover.sv - self-checking bench for adc_offset_remover with a 16-sample window
module tb_adc_offset_remover;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cal_restart;
  logic [7:0] dc_est;
  logic       dc_locked;

  always #5 clk = ~clk;

  adc_offset_remover_if #(.DATA_W(8)) s_if ();
  adc_offset_remover_if #(.DATA_W(8)) m_if ();

  adc_offset_remover #(
    .DATA_W   (8),
    .AVG_LOG2 (4),
    .MID_CODE (127)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s_if),
    .m           (m_if),
    .dc_est      (dc_est),
    .dc_locked   (dc_locked),
    .cal_restart (cal_restart)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit collect  = 1'b0;
  int got[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int d);
    if (d > 127) return 127;
    if (d < -127) return -127;
    return d;
  endfunction

  // Reference: expected outputs from accepted samples, window averages and restarts.
  int e_dc, e_sum, e_cnt, e_s1d, e_od;
  bit e_locked, e_s1v, e_ov;

  always @(posedge clk) begin
    bit en;
    if (!rst_n) begin
      e_dc = 127; e_locked = 0; e_sum = 0; e_cnt = 0;
      e_s1v = 0; e_s1d = 0; e_ov = 0; e_od = 0;
    end else begin
      en = !e_ov || m_if.ready;
      if (en) begin
        e_ov  = e_s1v;
        e_od  = clamp(e_s1d - e_dc);
        e_s1v = s_if.valid;
        e_s1d = s_if.data;
      end
      if (cal_restart) begin
        e_dc = 127; e_locked = 0; e_sum = 0; e_cnt = 0;
      end else if (s_if.valid && en) begin
        e_sum += s_if.data;
        e_cnt++;
        if (e_cnt == WIN) begin
          e_dc = (e_sum + WIN / 2) / WIN;
          if (e_dc > 255) e_dc = 255;
          e_locked = 1; e_sum = 0; e_cnt = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (collect && rst_n && m_if.valid && m_if.ready) got.push_back(int'($signed(m_if.data)));
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("m_valid", m_if.valid, e_ov);
      chk("s_ready", s_if.ready, (!e_ov || m_if.ready));
      chk("dc_est", dc_est, e_dc);
      chk("dc_locked", dc_locked, e_locked);
      if (e_ov) chk("m_data", $signed(m_if.data), e_od);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic cr);
    s_if.valid  = v;
    s_if.data   = d;
    m_if.ready  = r;
    cal_restart = cr;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[4];
    int i;
    int cyc;
    bit took;
    pat = '{1, 0, 0, 1};
    s_if.valid = 0; s_if.data = 0; m_if.ready = 1; cal_restart = 0; rst_n = 0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_dc_est", dc_est, 127);
    chk("rst_dc_locked", dc_locked, 0);
    chk("rst_s_ready", s_if.ready, 1);
    rst_n = 1;

    repeat (3) drive(1, 8'd127, 1, 0);
    chk("mid_m_data", $signed(m_if.data), 0);
    repeat (12) drive(1, 8'd127, 1, 0);
    chk("pre_lock", dc_locked, 0);
    drive(1, 8'd127, 1, 0);
    chk("lock127_est", dc_est, 127);
    chk("lock127_locked", dc_locked, 1);

    drive(0, 8'd0, 1, 1);
    chk("restart_unlock", dc_locked, 0);
    repeat (3) drive(1, 8'd140, 1, 0);
    chk("prelock_140", $signed(m_if.data), 13);
    repeat (13) drive(1, 8'd140, 1, 0);
    chk("lock140_est", dc_est, 140);
    chk("lock140_locked", dc_locked, 1);
    repeat (2) drive(1, 8'd140, 1, 0);
    chk("post_lock_140", $signed(m_if.data), 0);

    drive(0, 8'd0, 1, 1);
    drive(1, 8'd255, 1, 0);
    drive(1, 8'd0, 1, 0);
    chk("sat_hi", $signed(m_if.data), 127);
    drive(0, 8'd0, 1, 0);
    chk("sat_lo", $signed(m_if.data), -127);
    repeat (3) drive(0, 8'd0, 1, 0);

    got.delete();
    collect = 1;
    i = 0;
    cyc = 0;
    while (i < 10 && cyc < 200) begin
      s_if.valid = 1; s_if.data = 8'(i); m_if.ready = 1'(pat[cyc % 4]); cal_restart = 0;
      #1;
      took = s_if.ready;
      @(negedge clk);
      cyc++;
      if (took) i++;
    end
    chk("bp_accept_all", i, 10);
    s_if.valid = 0;
    repeat (16) begin
      m_if.ready = 1'(pat[cyc % 4]);
      @(negedge clk);
      cyc++;
    end
    m_if.ready = 1;
    collect = 0;
    chk("bp_count", got.size(), 10);
    for (int k = 0; k < got.size() && k < 10; k++) chk("bp_order", got[k], -127 + k);

    drive(0, 8'd0, 1, 1);
    repeat (16) drive(1, 8'd140, 1, 0);
    chk("track140_est", dc_est, 140);
    repeat (15) drive(1, 8'd140, 1, 0);
    drive(1, 8'd140, 1, 1);
    chk("restart_win_est", dc_est, 127);
    chk("restart_win_locked", dc_locked, 0);
    repeat (8) drive(1, 8'd100, 1, 0);
    repeat (8) drive(1, 8'd101, 1, 0);
    chk("relock_round_est", dc_est, 101);
    chk("relock_locked", dc_locked, 1);

    repeat (3) drive(1, 8'd50, 1, 0);
    rst_n = 0;
    drive(1, 8'd50, 1, 0);
    chk("midrst_m_valid", m_if.valid, 0);
    chk("midrst_dc_est", dc_est, 127);
    chk("midrst_locked", dc_locked, 0);
    rst_n = 1;
    repeat (4) drive(1, 8'd60, 1, 0);
    repeat (3) drive(0, 8'd0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
